// File: rtl/uart_imem_loader.sv
// uart_imem_loader: receives a framed program over an 8N1 UART line and writes
// it word by word into instruction memory while holding the core in reset.
// Frame: SYNC_BYTE, word count N, 4*N data bytes (little-endian words), XOR checksum.

module uart_imem_loader #(
  parameter int         CLKS_PER_BIT = 104,
  parameter int         MAX_WORDS    = 14,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RX,
  output logic        WE,
  output logic [31:0] A,
  output logic [31:0] WD,
  output logic        CORE_RST,
  output logic        DONE,
  output logic        ERR
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]       MAX_N     = 8'(MAX_WORDS);

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    LD_SYNC = 2'd0, LD_COUNT = 2'd1, LD_DATA = 2'd2, LD_CHECK = 2'd3
  } ld_state_t;

  logic             rx_meta_r, rx_sync_r;
  rx_state_t        rx_state_r, rx_state_next_s;
  logic [CNT_W-1:0] clk_cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       rx_byte_r;
  logic             byte_valid_r, frame_err_r;
  logic             half_tick_s, bit_tick_s;

  ld_state_t        ld_state_r, ld_state_next_s;
  logic [7:0]       word_cnt_r, word_idx_r, csum_r;
  logic [1:0]       byte_idx_r;
  logic [23:0]      word_buf_r;
  logic             start_s, abort_s, count_load_s, count_bad_s;
  logic             data_byte_s, word_write_s, last_word_s, last_write_s;
  logic             check_byte_s, csum_ok_s, csum_bad_s;

  assign half_tick_s = (clk_cnt_r == HALF_LAST);
  assign bit_tick_s  = (clk_cnt_r == BIT_LAST);

  // Two-flop synchronizer for the asynchronous RX line, reset to idle-high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= RX;
      rx_sync_r <= rx_meta_r;
    end
  end

  // RX bit-engine state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rx_state_r <= RX_IDLE;
    else     rx_state_r <= rx_state_next_s;
  end

  // RX bit-engine next state: start edge, mid-start recheck, 8 data bits, stop bit.
  always_comb begin
    rx_state_next_s = rx_state_r;
    case (rx_state_r)
      RX_IDLE:  if (!rx_sync_r) rx_state_next_s = RX_START; else rx_state_next_s = RX_IDLE;
      RX_START: if (half_tick_s) rx_state_next_s = rx_sync_r ? RX_IDLE : RX_DATA;
                else rx_state_next_s = RX_START;
      RX_DATA:  if (bit_tick_s && (bit_idx_r == 3'd7)) rx_state_next_s = RX_STOP;
                else rx_state_next_s = RX_DATA;
      RX_STOP:  if (bit_tick_s) rx_state_next_s = RX_IDLE; else rx_state_next_s = RX_STOP;
      default:  rx_state_next_s = RX_IDLE;
    endcase
  end

  // RX bit timing, LSB-first shift register and the byte-valid / framing-error pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      clk_cnt_r    <= '0;
      bit_idx_r    <= 3'd0;
      rx_byte_r    <= 8'd0;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          clk_cnt_r <= '0;
          bit_idx_r <= 3'd0;
        end
        RX_START: clk_cnt_r <= half_tick_s ? '0 : clk_cnt_r + 1'b1;
        RX_DATA: begin
          if (bit_tick_s) begin
            clk_cnt_r <= '0;
            rx_byte_r <= {rx_sync_r, rx_byte_r[7:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
          end else begin
            clk_cnt_r <= clk_cnt_r + 1'b1;
          end
        end
        RX_STOP: begin
          if (bit_tick_s) begin
            clk_cnt_r    <= '0;
            byte_valid_r <= rx_sync_r;
            frame_err_r  <= ~rx_sync_r;
          end else begin
            clk_cnt_r <= clk_cnt_r + 1'b1;
          end
        end
        default: clk_cnt_r <= '0;
      endcase
    end
  end

  // Loader FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ld_state_r <= LD_SYNC;
    else     ld_state_r <= ld_state_next_s;
  end

  // Loader action decode: what the current byte-valid / framing-error pulse means.
  always_comb begin
    start_s      = (ld_state_r == LD_SYNC) && byte_valid_r && (rx_byte_r == SYNC_BYTE);
    abort_s      = (ld_state_r != LD_SYNC) && frame_err_r;
    count_load_s = (ld_state_r == LD_COUNT) && byte_valid_r &&
                   (rx_byte_r != 8'd0) && (rx_byte_r <= MAX_N);
    count_bad_s  = (ld_state_r == LD_COUNT) && byte_valid_r && !count_load_s;
    data_byte_s  = (ld_state_r == LD_DATA) && byte_valid_r;
    word_write_s = data_byte_s && (byte_idx_r == 2'd3);
    last_word_s  = (word_idx_r == (word_cnt_r - 8'd1));
    last_write_s = word_write_s && last_word_s;
    check_byte_s = (ld_state_r == LD_CHECK) && byte_valid_r;
    csum_ok_s    = check_byte_s && (rx_byte_r == csum_r);
    csum_bad_s   = check_byte_s && (rx_byte_r != csum_r);
  end

  // Loader next state; every error and every checksum byte lands back in SYNC.
  always_comb begin
    ld_state_next_s = ld_state_r;
    if (abort_s || count_bad_s || check_byte_s) ld_state_next_s = LD_SYNC;
    else if (start_s)                           ld_state_next_s = LD_COUNT;
    else if (count_load_s)                      ld_state_next_s = LD_DATA;
    else if (last_write_s)                      ld_state_next_s = LD_CHECK;
    else                                        ld_state_next_s = ld_state_r;
  end

  // Loader datapath and registered memory/status outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      WE         <= 1'b0;
      A          <= 32'd0;
      WD         <= 32'd0;
      CORE_RST   <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
      word_cnt_r <= 8'd0;
      word_idx_r <= 8'd0;
      byte_idx_r <= 2'd0;
      csum_r     <= 8'd0;
      word_buf_r <= 24'd0;
    end else begin
      WE <= 1'b0;
      if (start_s) begin
        CORE_RST   <= 1'b1;
        DONE       <= 1'b0;
        ERR        <= 1'b0;
        word_idx_r <= 8'd0;
        byte_idx_r <= 2'd0;
        csum_r     <= 8'd0;
      end
      if (abort_s || count_bad_s || csum_bad_s) ERR <= 1'b1;
      if (count_load_s) word_cnt_r <= rx_byte_r;
      if (data_byte_s) begin
        csum_r     <= csum_r ^ rx_byte_r;
        byte_idx_r <= byte_idx_r + 2'd1;
        case (byte_idx_r)
          2'd0: word_buf_r[7:0]   <= rx_byte_r;
          2'd1: word_buf_r[15:8]  <= rx_byte_r;
          2'd2: word_buf_r[23:16] <= rx_byte_r;
          2'd3: begin
            WE <= 1'b1;
            A  <= {22'd0, word_idx_r, 2'b00};
            WD <= {rx_byte_r, word_buf_r};
            if (!last_word_s) word_idx_r <= word_idx_r + 8'd1;
          end
          default: word_buf_r <= word_buf_r;
        endcase
      end
      if (csum_ok_s) begin
        DONE     <= 1'b1;
        CORE_RST <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
// tb_uart_imem_loader: directed and randomized frames driven over RX, checked
// against a whole-frame reference model of the loader.

module tb_uart_imem_loader;

  localparam int         CPB   = 16;
  localparam int         MAXW  = 14;
  localparam logic [7:0] SYNCB = 8'hA5;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        RX  = 1'b1;
  logic        WE;
  logic [31:0] A, WD;
  logic        CORE_RST, DONE, ERR;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0]  frame_q[$];
  int          bad_idx = -1;
  logic [31:0] log_a[$], log_wd[$];
  int          core_hi_cnt = 0;
  logic [31:0] exp_a[$], exp_wd[$];
  logic        m_done = 1'b0, m_err = 1'b0, m_core = 1'b0, exp_sync = 1'b0;
  logic [31:0] m_last_a = 32'd0, m_last_wd = 32'd0;

  uart_imem_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(MAXW), .SYNC_BYTE(SYNCB)) dut (
    .CLK(CLK), .RST(RST), .RX(RX), .WE(WE), .A(A), .WD(WD),
    .CORE_RST(CORE_RST), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Log every write-enable cycle and count cycles with the core held in reset.
  always @(negedge CLK) begin
    if (WE === 1'b1) begin
      log_a.push_back(A);
      log_wd.push_back(WD);
    end
    if (CORE_RST === 1'b1) core_hi_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    RX = 1'b0; cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      RX = b[i]; cyc(CPB);
    end
    RX = stop; cyc(CPB);
    RX = 1'b1; cyc(2);
  endtask

  task automatic glitch();
    RX = 1'b0; cyc(3);
    RX = 1'b1; cyc(CPB);
  endtask

  // Whole-frame reference: locate the sync marker, decode count, words and checksum.
  task automatic model_frame();
    int valid_len, p, n, avail, nw, base;
    logic [7:0] cs;
    valid_len = (bad_idx >= 0) ? bad_idx : frame_q.size();
    exp_a.delete();
    exp_wd.delete();
    p = -1;
    for (int i = 0; i < valid_len; i++)
      if (p < 0 && frame_q[i] == SYNCB) p = i;
    exp_sync = (p >= 0);
    if (p < 0) return;
    m_done = 1'b0; m_err = 1'b0; m_core = 1'b1;
    if (p + 1 >= valid_len) begin
      m_err = (bad_idx >= 0);
      return;
    end
    n = int'(frame_q[p+1]);
    if (n == 0 || n > MAXW) begin
      m_err = 1'b1;
      return;
    end
    avail = valid_len - (p + 2);
    nw = (avail / 4 < n) ? avail / 4 : n;
    for (int w = 0; w < nw; w++) begin
      base = p + 2 + 4 * w;
      m_last_a  = 32'(w * 4);
      m_last_wd = {frame_q[base+3], frame_q[base+2], frame_q[base+1], frame_q[base]};
      exp_a.push_back(m_last_a);
      exp_wd.push_back(m_last_wd);
    end
    if (avail > 4 * n) begin
      cs = 8'd0;
      for (int i = 0; i < 4 * n; i++) cs ^= frame_q[p+2+i];
      if (frame_q[p+2+4*n] == cs) begin
        m_done = 1'b1; m_core = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end else begin
      m_err = (bad_idx >= 0);
    end
  endtask

  task automatic run_frame(input string name, input int glitch_after);
    int wbase, cbase, nw;
    logic prev_core;
    wbase = log_a.size();
    cbase = core_hi_cnt;
    prev_core = m_core;
    for (int i = 0; i < frame_q.size(); i++) begin
      if (bad_idx < 0 || i <= bad_idx) begin
        send_byte(frame_q[i], (i != bad_idx));
        if (i == glitch_after) glitch();
      end
    end
    cyc(4);
    if (bad_idx >= 0) cyc(12 * CPB);
    model_frame();
    nw = log_a.size() - wbase;
    check({name, " writes"}, 32'(nw), 32'(exp_a.size()));
    for (int w = 0; w < exp_a.size() && w < nw; w++) begin
      check({name, " A"}, log_a[wbase+w], exp_a[w]);
      check({name, " WD"}, log_wd[wbase+w], exp_wd[w]);
    end
    check({name, " DONE"}, 32'(DONE), 32'(m_done));
    check({name, " ERR"}, 32'(ERR), 32'(m_err));
    check({name, " CORE_RST"}, 32'(CORE_RST), 32'(m_core));
    check({name, " A hold"}, A, m_last_a);
    check({name, " WD hold"}, WD, m_last_wd);
    check({name, " core held"}, 32'(core_hi_cnt != cbase), 32'(exp_sync || prev_core));
  endtask

  initial begin
    int wbase, nj, n;
    logic [7:0] b, cs;

    // Asynchronous reset with no clock edge in between.
    #2 RST = 1'b1;
    #1;
    check("rst WE", 32'(WE), 32'd0);
    check("rst A", A, 32'd0);
    check("rst WD", WD, 32'd0);
    check("rst CORE_RST", 32'(CORE_RST), 32'd0);
    check("rst DONE", 32'(DONE), 32'd0);
    check("rst ERR", 32'(ERR), 32'd0);
    cyc(3);
    RST = 1'b0;
    cyc(5);

    // Two-word program; checksum is the XOR of the eight data bytes (0x37).
    frame_q = '{8'hA5, 8'h02, 8'h93, 8'h00, 8'h10, 8'h00, 8'h37, 8'h03, 8'h00, 8'h80, 8'h37};
    bad_idx = -1;
    run_frame("prog ok", -1);
    check("prog ok WD0", log_wd[log_wd.size()-2], 32'h00100093);
    check("prog ok WD1", log_wd[log_wd.size()-1], 32'h80000337);

    // Idle-line glitch then a non-sync byte: nothing changes.
    glitch();
    frame_q = '{8'h55};
    run_frame("glitch 55", -1);

    // 55 ignored, A5 starts a frame, 0F is an oversize count.
    frame_q = '{8'h55, 8'hA5, 8'h0F};
    run_frame("55 A5 0F", -1);

    // Same program with a wrong checksum.
    frame_q = '{8'hA5, 8'h02, 8'h93, 8'h00, 8'h10, 8'h00, 8'h37, 8'h03, 8'h00, 8'h80, 8'h00};
    run_frame("prog bad cs", -1);

    frame_q = '{8'hA5, 8'h0F};
    run_frame("count 15", -1);
    frame_q = '{8'hA5, 8'h00};
    run_frame("count 0", -1);

    // Sync-marker values inside a frame are plain data.
    frame_q = '{8'hA5, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00};
    run_frame("A5 data", -1);

    // Framing error on the third data byte, then a clean reload.
    frame_q = '{8'hA5, 8'h02, 8'h93, 8'h00, 8'h10, 8'h00, 8'h37, 8'h03, 8'h00, 8'h80, 8'h37};
    bad_idx = 4;
    run_frame("stop err", -1);
    bad_idx = -1;
    run_frame("reload", -1);

    // Glitch right after the sync byte must not become a count byte.
    run_frame("glitch in frame", 0);

    // Randomized frames; the last one fills every word.
    for (int f = 0; f < 7; f++) begin
      frame_q.delete();
      bad_idx = -1;
      nj = $urandom_range(0, 2);
      repeat (nj) begin
        b = 8'($urandom_range(0, 255));
        if (b == SYNCB) b = 8'h5A;
        frame_q.push_back(b);
      end
      n = (f == 6) ? MAXW : $urandom_range(1, 4);
      frame_q.push_back(SYNCB);
      frame_q.push_back(8'(n));
      cs = 8'd0;
      repeat (4 * n) begin
        b = 8'($urandom_range(0, 255));
        cs ^= b;
        frame_q.push_back(b);
      end
      if ($urandom_range(0, 2) == 0) cs ^= 8'($urandom_range(1, 255));
      frame_q.push_back(cs);
      if (f != 6 && $urandom_range(0, 4) == 0)
        bad_idx = nj + $urandom_range(1, frame_q.size() - 1 - nj);
      run_frame("rand", -1);
    end
    bad_idx = -1;
    check("max A", log_a[log_a.size()-1], 32'((MAXW - 1) * 4));

    // Reset after two data bytes: outputs clear at once, no write afterwards.
    wbase = log_a.size();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h93, 1'b1);
    send_byte(8'h00, 1'b1);
    check("mid CORE_RST", 32'(CORE_RST), 32'd1);
    #2 RST = 1'b1;
    #1;
    check("mid rst WE", 32'(WE), 32'd0);
    check("mid rst A", A, 32'd0);
    check("mid rst WD", WD, 32'd0);
    check("mid rst CORE_RST", 32'(CORE_RST), 32'd0);
    check("mid rst DONE", 32'(DONE), 32'd0);
    check("mid rst ERR", 32'(ERR), 32'd0);
    cyc(2);
    RST = 1'b0;
    cyc(20 * CPB);
    check("post rst writes", 32'(log_a.size() - wbase), 32'd0);
    check("post rst CORE_RST", 32'(CORE_RST), 32'd0);
    check("post rst DONE", 32'(DONE), 32'd0);
    check("post rst ERR", 32'(ERR), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
